// File: rtl/txn_bus_master_if.sv
// Request, bus command/reply and response channels of txn_bus_master.
// The master modport is the txn_bus_master side; slave is the requester/bus-target side.
interface txn_bus_master_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int DLY_W  = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic [DLY_W-1:0]  req_delay;

    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_ack;
    logic [DATA_W-1:0] bus_rdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    modport master (
        input  req_valid, req_we, req_addr, req_data, req_delay,
        input  bus_ack, bus_rdata, rsp_ready,
        output req_ready, bus_req, bus_we, bus_addr, bus_wdata,
        output rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        output req_valid, req_we, req_addr, req_data, req_delay,
        output bus_ack, bus_rdata, rsp_ready,
        input  req_ready, bus_req, bus_we, bus_addr, bus_wdata,
        input  rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/txn_bus_master.sv
// Single-outstanding bus master: accept a request, wait req_delay cycles, run one bus transfer
// (ack or TIMEOUT), then hold one response until rsp_ready; req_ready is only high in IDLE.
module txn_bus_master #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int DLY_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    txn_bus_master_if.master bus
);
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        BUS   = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state_q;
    logic [DLY_W-1:0]  dly_q;
    logic [TO_W-1:0]   tcnt_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              bus_req_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            dly_q       <= '0;
            tcnt_q      <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            bus_req_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q    <= bus.req_we;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_data;
                        tcnt_q  <= '0;
                        if (bus.req_delay == '0) begin
                            state_q   <= BUS;
                            bus_req_q <= 1'b1;
                        end else begin
                            state_q <= DELAY;
                            dly_q   <= bus.req_delay;
                        end
                    end
                end
                DELAY: begin
                    // Leaving at a count of 1 puts bus_req onset at delay+1 cycles after accept.
                    if (dly_q == DLY_W'(1)) begin
                        state_q   <= BUS;
                        bus_req_q <= 1'b1;
                        dly_q     <= '0;
                    end else begin
                        dly_q <= dly_q - DLY_W'(1);
                    end
                end
                BUS: begin
                    if (bus.bus_ack) begin
                        state_q     <= RESP;
                        bus_req_q   <= 1'b0;
                        tcnt_q      <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= we_q ? '0 : bus.bus_rdata;
                        rsp_err_q   <= 1'b0;
                    end else if (tcnt_q == TO_W'(TIMEOUT - 1)) begin
                        state_q     <= RESP;
                        bus_req_q   <= 1'b0;
                        tcnt_q      <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b1;
                    end else begin
                        tcnt_q <= tcnt_q + TO_W'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Gated by reset so the requester never sees ready while reset is held.
    assign bus.req_ready = (state_q == IDLE) && !reset;

    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = bus_req_q & we_q;
    assign bus.bus_addr  = bus_req_q ? addr_q  : '0;
    assign bus.bus_wdata = bus_req_q ? wdata_q : '0;

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_txn_bus_master.sv
// Bench for txn_bus_master: directed cases, reset abort cases and 50 random transactions
// checked against a transaction-level model of onset timing and response contents.
module tb_txn_bus_master;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 16;
    localparam int DLY_W   = 8;
    localparam int TIMEOUT = 64;
    localparam int NRND    = 50;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              err;
    } rsp_t;

    rsp_t exp_q[$];

    txn_bus_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DLY_W(DLY_W)) bif();

    txn_bus_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DLY_W(DLY_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.master)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // What a requester should get back: data only for acked reads, error only on timeout.
    function automatic rsp_t model(input logic we, input int ack_lat, input logic [DATA_W-1:0] rdata);
        rsp_t r;
        r.err  = (ack_lat >= TIMEOUT);
        r.data = (r.err || we) ? '0 : rdata;
        return r;
    endfunction

    task automatic idle_inputs();
        bif.req_valid = 1'b0;
        bif.req_we    = 1'b0;
        bif.req_addr  = '0;
        bif.req_data  = '0;
        bif.req_delay = '0;
        bif.bus_ack   = 1'b0;
        bif.bus_rdata = '0;
        bif.rsp_ready = 1'b0;
    endtask

    task automatic start_req(input logic we, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] wdata, input logic [DLY_W-1:0] dly);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bif.req_ready) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("req_ready_idle", 32'(seen), 32'd1);
        bif.req_valid = 1'b1;
        bif.req_we    = we;
        bif.req_addr  = addr;
        bif.req_data  = wdata;
        bif.req_delay = dly;
        @(negedge clk);
        bif.req_valid = 1'b0;
        bif.req_addr  = ADDR_W'($urandom);
        bif.req_data  = DATA_W'($urandom);
        bif.req_delay = DLY_W'($urandom);
        chk("req_ready_busy", 32'(bif.req_ready), 32'd0);
    endtask

    task automatic run_txn(input logic we, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wdata, input logic [DLY_W-1:0] dly,
                           input int ack_lat, input logic [DATA_W-1:0] rdata,
                           input int rsp_wait, input bit noisy_ack);
        rsp_t e;
        int   n;
        int   k;
        start_req(we, addr, wdata, dly);
        n = 1;
        while (!bif.bus_req && n <= int'(dly) + 4) begin
            if (noisy_ack) bif.bus_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        bif.bus_ack = 1'b0;
        chk("bus_req_onset", 32'(n), 32'(int'(dly) + 1));
        k = 0;
        while (bif.bus_req && k < TIMEOUT + 4) begin
            chk("bus_we", 32'(bif.bus_we), 32'(we));
            chk("bus_addr", 32'(bif.bus_addr), 32'(addr));
            chk("bus_wdata", 32'(bif.bus_wdata), 32'(wdata));
            if (k == ack_lat) begin
                bif.bus_ack   = 1'b1;
                bif.bus_rdata = rdata;
            end else begin
                bif.bus_ack   = 1'b0;
                bif.bus_rdata = DATA_W'($urandom);
            end
            @(negedge clk);
            k++;
        end
        bif.bus_ack = 1'b0;
        chk("bus_req_cycles", 32'(k), 32'((ack_lat >= TIMEOUT) ? TIMEOUT : ack_lat + 1));
        chk("bus_idle_addr", 32'(bif.bus_addr), 32'd0);
        e = exp_q.pop_front();
        chk("rsp_valid", 32'(bif.rsp_valid), 32'd1);
        chk("rsp_data", 32'(bif.rsp_data), 32'(e.data));
        chk("rsp_err", 32'(bif.rsp_err), 32'(e.err));
        for (int i = 0; i < rsp_wait; i++) begin
            @(negedge clk);
            chk("rsp_hold_valid", 32'(bif.rsp_valid), 32'd1);
            chk("rsp_hold_data", 32'(bif.rsp_data), 32'(e.data));
            chk("rsp_hold_err", 32'(bif.rsp_err), 32'(e.err));
            chk("rsp_hold_req_ready", 32'(bif.req_ready), 32'd0);
            chk("rsp_hold_bus_req", 32'(bif.bus_req), 32'd0);
        end
        bif.rsp_ready = 1'b1;
        @(negedge clk);
        bif.rsp_ready = 1'b0;
        chk("rsp_released", 32'(bif.rsp_valid), 32'd0);
        chk("rsp_data_idle", 32'(bif.rsp_data), 32'd0);
        chk("req_ready_after_rsp", 32'(bif.req_ready), 32'd1);
    endtask

    task automatic check_quiet_after_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("req_ready_post_reset", 32'(bif.req_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("no_rsp_after_abort", 32'(bif.rsp_valid), 32'd0);
            chk("no_bus_after_abort", 32'(bif.bus_req), 32'd0);
        end
    endtask

    logic              r_we    [NRND];
    logic [ADDR_W-1:0] r_addr  [NRND];
    logic [DATA_W-1:0] r_wdata [NRND];
    logic [DLY_W-1:0]  r_dly   [NRND];
    int                r_ack   [NRND];
    logic [DATA_W-1:0] r_rdata [NRND];
    int                r_wait  [NRND];

    initial begin
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_req_ready", 32'(bif.req_ready), 32'd0);
        chk("reset_bus_req", 32'(bif.bus_req), 32'd0);
        chk("reset_bus_addr", 32'(bif.bus_addr), 32'd0);
        chk("reset_rsp_valid", 32'(bif.rsp_valid), 32'd0);
        chk("reset_rsp_data", 32'(bif.rsp_data), 32'd0);
        chk("reset_rsp_err", 32'(bif.rsp_err), 32'd0);
        reset = 1'b0;
        #1;
        chk("req_ready_first_cycle", 32'(bif.req_ready), 32'd1);

        exp_q.push_back(model(1'b1, 1, 16'h0000));
        run_txn(1'b1, 16'h0010, 16'hBEEF, 8'd0, 1, 16'h0000, 0, 1'b0);

        exp_q.push_back(model(1'b0, 0, 16'hA5A5));
        run_txn(1'b0, 16'h1234, 16'h0000, 8'd5, 0, 16'hA5A5, 0, 1'b1);

        exp_q.push_back(model(1'b0, 1000, 16'h5A5A));
        run_txn(1'b0, 16'h0BAD, 16'h0000, 8'd0, 1000, 16'h5A5A, 0, 1'b0);

        exp_q.push_back(model(1'b0, 2, 16'h1357));
        run_txn(1'b0, 16'h2222, 16'h3333, 8'd1, 2, 16'h1357, 10, 1'b0);

        exp_q.push_back(model(1'b0, TIMEOUT - 1, 16'hC0DE));
        run_txn(1'b0, 16'h4444, 16'h0000, 8'd2, TIMEOUT - 1, 16'hC0DE, 1, 1'b0);

        exp_q.push_back(model(1'b1, TIMEOUT, 16'hFFFF));
        run_txn(1'b1, 16'h5555, 16'h6666, 8'd0, TIMEOUT, 16'hFFFF, 0, 1'b0);

        exp_q.push_back(model(1'b0, 3, 16'h0F0F));
        run_txn(1'b0, 16'hFFFF, 16'h0000, 8'd255, 3, 16'h0F0F, 2, 1'b1);

        // Abort in DELAY.
        start_req(1'b0, 16'h7777, 16'h0000, 8'd10);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("delay_abort_req_ready", 32'(bif.req_ready), 32'd0);
        chk("delay_abort_bus_req", 32'(bif.bus_req), 32'd0);
        check_quiet_after_reset();

        // Abort in BUS: bus_req must drop without waiting for a clock edge.
        start_req(1'b1, 16'h8888, 16'h9999, 8'd0);
        chk("bus_abort_pre", 32'(bif.bus_req), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("bus_abort_bus_req", 32'(bif.bus_req), 32'd0);
        chk("bus_abort_bus_addr", 32'(bif.bus_addr), 32'd0);
        chk("bus_abort_req_ready", 32'(bif.req_ready), 32'd0);
        check_quiet_after_reset();

        for (int i = 0; i < NRND; i++) begin
            r_we[i]    = 1'($urandom_range(0, 1));
            r_addr[i]  = ADDR_W'($urandom);
            r_wdata[i] = DATA_W'($urandom);
            r_dly[i]   = ($urandom_range(0, 3) == 0) ? 8'd0 : DLY_W'($urandom_range(1, 9));
            r_ack[i]   = ($urandom_range(0, 9) == 0) ? TIMEOUT + 5 : int'($urandom_range(0, 5));
            r_rdata[i] = DATA_W'($urandom);
            r_wait[i]  = int'($urandom_range(0, 3));
            exp_q.push_back(model(r_we[i], r_ack[i], r_rdata[i]));
        end
        for (int i = 0; i < NRND; i++) begin
            run_txn(r_we[i], r_addr[i], r_wdata[i], r_dly[i], r_ack[i], r_rdata[i], r_wait[i], 1'b1);
        end
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/txn_bus_master.md
TXN_BUS_MASTER -- requirements
Module: txn_bus_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, address width.
REQ-002 SHALL have parameter DATA_W, default 16, data width.
REQ-003 SHALL have parameter DLY_W, default 8, width of the per-transaction delay field.
REQ-004 SHALL have parameter TIMEOUT, default 64, maximum bus wait in cycles before error (must be >= 1).
REQ-005 SHALL use one clock and an asynchronous, active-high reset.
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-008 SHALL have ports req_valid in 1, req_ready out 1 as the transaction request handshake.
REQ-009 SHALL have ports req_we in 1 (1=write, 0=read), req_addr in ADDR_W, req_data in DATA_W, req_delay in DLY_W.
REQ-010 SHALL have ports bus_req out 1, bus_we out 1, bus_addr out ADDR_W, bus_wdata out DATA_W as the bus command.
REQ-011 SHALL have ports bus_ack in 1, bus_rdata in DATA_W as the bus reply.
REQ-012 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_data out DATA_W, rsp_err out 1 as the response channel.

Function
REQ-013 SHALL implement FSM states IDLE, DELAY, BUS, RESP; one transaction in flight at a time.
REQ-014 SHALL drive req_ready=1 only in IDLE; acceptance = req_valid && req_ready on a rising edge; all request fields captured at acceptance.
REQ-015 SHALL, on acceptance, go to BUS if req_delay==0, else to DELAY with counter loaded to req_delay.
REQ-016 SHALL in DELAY decrement the counter each cycle and enter BUS when it reaches 1, so bus_req first rises exactly req_delay+1 cycles after acceptance (max delay 2^DLY_W-1).
REQ-017 SHALL in BUS hold bus_req=1 with bus_we/bus_addr/bus_wdata stable at captured values until bus_ack is sampled high; ack in the first bus_req cycle is valid.
REQ-018 SHALL drive bus_req=0 and bus_we/bus_addr/bus_wdata=0 outside BUS; bus_ack outside BUS is ignored.
REQ-019 SHALL on bus_ack enter RESP with rsp_data=bus_rdata for reads, rsp_data=0 for writes, rsp_err=0.
REQ-020 SHALL count BUS cycles; if TIMEOUT cycles elapse with no ack, drop bus_req next cycle and enter RESP with rsp_err=1, rsp_data=0.
REQ-021 SHALL in RESP hold rsp_valid=1 and rsp_data/rsp_err stable until rsp_ready sampled high, then return to IDLE (req_ready=1 the following cycle; no same-cycle accept).
REQ-022 SHALL drive rsp_valid=0, rsp_data=0, rsp_err=0 outside RESP.
REQ-023 SHALL produce exactly one response per accepted request, for reads and writes alike.

Reset
REQ-024 SHALL on reset assertion immediately force state IDLE, counters 0, bus_req=0, rsp_valid=0, all data outputs 0, req_ready=0 while reset is high.
REQ-025 SHALL abandon any in-flight transaction on reset without emitting a response; req_ready=1 in the first cycle after reset deasserts.

Verification
REQ-026 Write addr=0x0010 data=0xBEEF delay=0, ack one cycle after bus_req -> bus_req rises 1 cycle after accept, bus_we=1, bus_wdata=0xBEEF, rsp_valid with rsp_data=0, rsp_err=0.
REQ-027 Read addr=0x1234 delay=5, bus_rdata=0xA5A5 on ack -> bus_req rises 6 cycles after accept, rsp_data=0xA5A5, rsp_err=0.
REQ-028 Read with bus_ack held 0, TIMEOUT=64 -> bus_req high exactly 64 cycles then low, rsp_err=1, rsp_data=0.
REQ-029 rsp_ready held 0 for 10 cycles -> rsp_valid/rsp_data stable throughout, req_ready=0, no second bus_req.
REQ-030 Reset asserted in DELAY and in BUS -> bus_req falls asynchronously, no response emitted, req_ready=1 first cycle after release.
REQ-031 Back-to-back 50 random read/write requests with random delays and ack latency -> responses in order, matching scoreboard, bus_req onset = delay+1 cycles after each accept.
